// File: rtl/axi_inval_buffer.sv
// Invalidation-request buffer between the AXI invalidation filter and CVA6.
// Aligns incoming byte addresses to L1 D-cache lines, merges requests that hit
// a pending line, and hands lines to CVA6 one at a time over valid/ready.
module axi_inval_buffer #(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned L1LineWidth = 16,
  parameter int unsigned Depth       = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic [AddrWidth-1:0]       in_addr_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [AddrWidth-1:0]       inval_addr_o,
  output logic                       inval_valid_o,
  input  logic                       inval_ready_i,
  output logic [$clog2(Depth+1)-1:0] pending_o,
  output logic [15:0]                coalesced_o
);

  localparam int unsigned LineLsb = $clog2(L1LineWidth);
  localparam int unsigned LineW   = AddrWidth - LineLsb;
  localparam int unsigned PtrW    = $clog2(Depth);
  localparam int unsigned CntW    = $clog2(Depth + 1);

  logic [LineW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic [15:0]      coalesced_q, coalesced_d;

  logic [LineW-1:0] in_line;
  logic [Depth-1:0] hit_vec;
  logic             hit, full, push, pop, merge;

  // Offset bits within a line never matter.
  logic unused_line_offset;
  assign unused_line_offset = ^in_addr_i[LineLsb-1:0];

  assign in_line = in_addr_i[AddrWidth-1:LineLsb];
  assign pop     = (count_q != '0) && inval_ready_i;
  assign full    = (count_q == CntW'(Depth));

  // Compare the incoming line against every occupied entry; the head is
  // excluded while it leaves this cycle so the request is not lost.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < Depth; i++) begin
      hit_vec[i] = (CntW'(PtrW'(PtrW'(i) - rd_ptr_q)) < count_q)
                   && !(pop && (PtrW'(i) == rd_ptr_q))
                   && (mem_q[i] == in_line);
    end
  end

  assign hit        = |hit_vec;
  // A pop does not free space for a push in the same cycle (no fall-through).
  assign in_ready_o = !en_i || hit || !full;
  assign push       = in_valid_i && en_i && !hit && !full;
  assign merge      = in_valid_i && en_i && hit;

  // Next-state for occupancy and the saturating merge counter.
  always_comb begin
    count_d     = count_q + CntW'(push) - CntW'(pop);
    coalesced_d = coalesced_q;
    if (merge && (coalesced_q != 16'hFFFF)) begin
      coalesced_d = coalesced_q + 16'd1;
    end
  end

  // Pointer, occupancy and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      coalesced_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q     <= count_d;
      coalesced_q <= coalesced_d;
    end
  end

  // Line storage; cleared on reset so the idle output address reads zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_line;
    end
  end

  assign inval_valid_o = (count_q != '0);
  assign inval_addr_o  = {mem_q[rd_ptr_q], {LineLsb{1'b0}}};
  assign pending_o     = count_q;
  assign coalesced_o   = coalesced_q;

endmodule

// File: tb/tb_axi_inval_buffer.sv
// Directed bench for axi_inval_buffer (AddrWidth=64, L1LineWidth=16, Depth=4).
module tb_axi_inval_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic [63:0] in_addr_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] inval_addr_o;
  logic        inval_valid_o;
  logic        inval_ready_i;
  logic [2:0]  pending_o;
  logic [15:0] coalesced_o;

  int checks = 0;
  int errors = 0;

  axi_inval_buffer #(
    .AddrWidth  (64),
    .L1LineWidth(16),
    .Depth      (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .in_addr_i    (in_addr_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .inval_addr_o (inval_addr_o),
    .inval_valid_o(inval_valid_o),
    .inval_ready_i(inval_ready_i),
    .pending_o    (pending_o),
    .coalesced_o  (coalesced_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic cycle();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic push(input logic [63:0] addr);
    in_valid_i = 1'b1;
    in_addr_i  = addr;
    cycle();
    in_valid_i = 1'b0;
  endtask

  logic [63:0] drain_exp [4];

  initial begin
    rst_ni        = 1'b0;
    en_i          = 1'b1;
    in_addr_i     = '0;
    in_valid_i    = 1'b0;
    inval_ready_i = 1'b0;
    #1;
    check("rst_pending", 64'(pending_o), 64'd0);
    check("rst_valid", 64'(inval_valid_o), 64'd0);
    check("rst_addr", inval_addr_o, 64'h0);
    check("rst_coalesced", 64'(coalesced_o), 64'd0);
    check("rst_in_ready", 64'(in_ready_o), 64'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle();

    // Single push, line alignment, single pop.
    push(64'h1004);
    check("t1_valid", 64'(inval_valid_o), 64'd1);
    check("t1_addr", inval_addr_o, 64'h1000);
    check("t1_pending", 64'(pending_o), 64'd1);
    inval_ready_i = 1'b1;
    cycle();
    inval_ready_i = 1'b0;
    check("t1_pop_pending", 64'(pending_o), 64'd0);
    check("t1_pop_valid", 64'(inval_valid_o), 64'd0);

    // Coalescing within one line.
    push(64'h2000);
    push(64'h2008);
    push(64'h200F);
    check("t2_pending", 64'(pending_o), 64'd1);
    check("t2_addr", inval_addr_o, 64'h2000);
    check("t2_coalesced", 64'(coalesced_o), 64'd2);
    inval_ready_i = 1'b1;
    cycle();
    inval_ready_i = 1'b0;
    check("t2_drained", 64'(pending_o), 64'd0);

    // Fill, refuse a miss when full, accept a hit when full.
    push(64'h00);
    push(64'h10);
    push(64'h20);
    push(64'h30);
    check("t3_full_pending", 64'(pending_o), 64'd4);
    in_valid_i = 1'b1;
    in_addr_i  = 64'h40;
    #1;
    check("t3_full_miss_ready", 64'(in_ready_o), 64'd0);
    in_addr_i = 64'h18;
    #1;
    check("t3_full_hit_ready", 64'(in_ready_o), 64'd1);
    cycle();
    in_valid_i = 1'b0;
    check("t3_hit_coalesced", 64'(coalesced_o), 64'd3);
    check("t3_hit_pending", 64'(pending_o), 64'd4);
    check("t3_head", inval_addr_o, 64'h00);

    // Full with a same-cycle pop: no fall-through.
    inval_ready_i = 1'b1;
    in_valid_i    = 1'b1;
    in_addr_i     = 64'h40;
    #1;
    check("t4_nofallthru_ready", 64'(in_ready_o), 64'd0);
    cycle();
    inval_ready_i = 1'b0;
    check("t4_after_pop_pending", 64'(pending_o), 64'd3);
    check("t4_after_pop_head", inval_addr_o, 64'h10);
    #1;
    check("t4_retry_ready", 64'(in_ready_o), 64'd1);
    cycle();
    in_valid_i = 1'b0;
    check("t4_retry_pending", 64'(pending_o), 64'd4);
    drain_exp[0] = 64'h10;
    drain_exp[1] = 64'h20;
    drain_exp[2] = 64'h30;
    drain_exp[3] = 64'h40;
    inval_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_drain%0d_valid", i), 64'(inval_valid_o), 64'd1);
      check($sformatf("t4_drain%0d_addr", i), inval_addr_o, drain_exp[i]);
      cycle();
    end
    inval_ready_i = 1'b0;
    check("t4_empty", 64'(pending_o), 64'd0);

    // Request to the head line while the head pops is enqueued, not merged.
    push(64'h3000);
    check("t5_head", inval_addr_o, 64'h3000);
    inval_ready_i = 1'b1;
    in_valid_i    = 1'b1;
    in_addr_i     = 64'h3004;
    #1;
    check("t5_ready", 64'(in_ready_o), 64'd1);
    cycle();
    inval_ready_i = 1'b0;
    in_valid_i    = 1'b0;
    check("t5_pending", 64'(pending_o), 64'd1);
    check("t5_addr", inval_addr_o, 64'h3000);
    check("t5_coalesced", 64'(coalesced_o), 64'd3);
    // Backpressure keeps the output stable.
    cycle();
    check("t5_stable_valid", 64'(inval_valid_o), 64'd1);
    check("t5_stable_addr", inval_addr_o, 64'h3000);
    inval_ready_i = 1'b1;
    cycle();
    inval_ready_i = 1'b0;

    // Disabled: dropped but acknowledged.
    en_i       = 1'b0;
    in_valid_i = 1'b1;
    in_addr_i  = 64'h5000;
    #1;
    check("t6_dis_ready", 64'(in_ready_o), 64'd1);
    cycle();
    in_valid_i = 1'b0;
    check("t6_dis_pending", 64'(pending_o), 64'd0);
    check("t6_dis_valid", 64'(inval_valid_o), 64'd0);
    en_i = 1'b1;

    // Asynchronous reset with three entries queued.
    push(64'h100);
    push(64'h200);
    push(64'h300);
    check("t6_pre_rst_pending", 64'(pending_o), 64'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_pending", 64'(pending_o), 64'd0);
    check("t6_rst_valid", 64'(inval_valid_o), 64'd0);
    check("t6_rst_addr", inval_addr_o, 64'h0);
    check("t6_rst_coalesced", 64'(coalesced_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle();
    check("t6_post_rst_valid", 64'(inval_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
